seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment glyph table and dark code.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_DARK = 7'h7F;

    // Active-low glyphs, bit0 = a ... bit6 = g, indexed by nibble value
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment decoder; codes 10-15 go dark outside hex mode.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             hex_mode,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_TABLE[nibble];
        if (!hex_mode && (nibble > 4'd9)) begin
            seg_c = SEG_DARK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned shadow loading,
// leading-zero suppression and PWM brightness with an anode dead band.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned TICK_DIV    = 32768,
    parameter int unsigned DEAD_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  hex_mode,
    input  logic                  lz_suppress,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   enable,
    output logic [SEG_W-1:0]      segment,
    output logic                  dp_n,
    output logic                  frame_done
);

    localparam int unsigned SW = $clog2(TICK_DIV);
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DW = 4 * N_DIGITS;

    logic [SW-1:0]       slot_cnt;
    logic [IW-1:0]       digit_idx;
    logic                slot_end;
    logic                boundary;
    logic [3:0]          phase;

    logic [DW-1:0]       pend_digits, act_digits;
    logic [N_DIGITS-1:0] pend_dp, act_dp;
    logic [N_DIGITS-1:0] pend_blank, act_blank;
    logic                pend_hex, act_hex;
    logic                pend_lz, act_lz;
    logic                pend_valid;

    logic [N_DIGITS-1:0] dark;
    logic                zero_above;
    logic [3:0]          cur_nibble;
    logic [SEG_W-1:0]    cur_seg_c;
    logic                lit;

    assign slot_end = (slot_cnt == SW'(TICK_DIV - 1));
    assign boundary = slot_end && (digit_idx == IW'(N_DIGITS - 1));
    assign phase    = slot_cnt[SW-1 -: 4];

    // Slot timer and digit scan position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
            if (slot_end) begin
                digit_idx <= boundary ? '0 : digit_idx + IW'(1);
            end
        end
    end

    // Pending/active display sets; active only changes on a frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            pend_hex    <= 1'b0;
            pend_lz     <= 1'b0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            act_hex     <= 1'b0;
            act_lz      <= 1'b0;
        end else begin
            if (load && !boundary) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_blank  <= blank_in;
                pend_hex    <= hex_mode;
                pend_lz     <= lz_suppress;
                pend_valid  <= 1'b1;
            end
            if (boundary) begin
                if (load) begin
                    act_digits <= digits_in;
                    act_dp     <= dp_in;
                    act_blank  <= blank_in;
                    act_hex    <= hex_mode;
                    act_lz     <= lz_suppress;
                end else if (pend_valid) begin
                    act_digits <= pend_digits;
                    act_dp     <= pend_dp;
                    act_blank  <= pend_blank;
                    act_hex    <= pend_hex;
                    act_lz     <= pend_lz;
                end
                pend_valid <= 1'b0;
            end
        end
    end

    // Darkness per digit; blanked digits count as zero for suppression below them
    always_comb begin
        dark       = '0;
        zero_above = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_blank[i] || (act_digits[4*i +: 4] == 4'd0));
            dark[i]    = act_blank[i]
                      || (!act_hex && (act_digits[4*i +: 4] > 4'd9))
                      || (act_lz && (i != 0) && zero_above);
        end
    end

    assign cur_nibble = act_digits[{digit_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble   (cur_nibble),
        .hex_mode (act_hex),
        .seg_c    (cur_seg_c)
    );

    assign lit = (slot_cnt >= SW'(DEAD_CYCLES)) && (phase <= brightness) && !dark[digit_idx];

    // Output stage: anode, segments and dp move together, one cycle after the scan state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable     <= '1;
            segment    <= SEG_DARK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            enable     <= lit ? ~(N_DIGITS'(1) << digit_idx) : '1;
            segment    <= lit ? cur_seg_c : SEG_DARK;
            dp_n       <= !(lit && act_dp[digit_idx]);
        end
    end

endmodule
